// File: rtl/ir_ctrl_seq.sv
// ir_ctrl_seq: multi-cycle fetch/decode/execute control sequencer with memory handshake timeout
module ir_ctrl_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       ir_re,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [2:0] alu_op,
  output logic       acc_we,
  output logic       acc_src,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, LATCH = 4'd2, DECODE = 4'd3, EXEC = 4'd4,
    MEM = 4'd5, WB = 4'd6, HALT = 4'd7, FAULT = 4'd8
  } state_t;
  state_t state;
  logic [3:0] op_q;
  logic [TO_W-1:0] cnt;
  logic expired, is_alu;
  assign expired = cnt == TO_W'(MEM_TIMEOUT - 1);
  assign is_alu = op_q >= 4'h3 && op_q <= 4'hA;
  // state sequencing; the timeout counter restarts after every ack so each FETCH/MEM entry starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q <= 4'h0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (mem_ack) begin
            state <= LATCH;
            cnt <= '0;
          end else if (expired) state <= FAULT;
          else cnt <= cnt + 1'b1;
        end
        LATCH: state <= DECODE;
        DECODE: begin
          op_q <= opcode;
          state <= (opcode == 4'h0) ? FETCH : (opcode <= 4'h2) ? MEM : (opcode <= 4'hC) ? EXEC : (opcode == 4'hF) ? HALT : FAULT;
        end
        EXEC: state <= is_alu ? WB : FETCH;
        MEM: begin
          if (mem_ack) begin
            state <= (op_q == 4'h1) ? WB : FETCH;
            cnt <= '0;
          end else if (expired) state <= FAULT;
          else cnt <= cnt + 1'b1;
        end
        WB: state <= FETCH;
        default: state <= state;
      endcase
    end
  end
  // strobes decoded from the state register so reset drops them immediately
  always_comb begin
    ir_re = state == LATCH;
    pc_inc = state == LATCH;
    pc_load = state == EXEC && (op_q == 4'hB || (op_q == 4'hC && zero));
    mem_req = state == FETCH || state == MEM;
    mem_we = state == MEM && op_q == 4'h2;
    addr_sel = state == MEM;
    alu_op = ((state == EXEC || state == WB) && is_alu) ? 3'(op_q - 4'h3) : 3'd0;
    acc_we = state == WB;
    acc_src = state == WB && op_q == 4'h1;
    halted = state == HALT;
    fault = state == FAULT;
    state_dbg = state;
  end
endmodule

// File: tb/tb_ir_ctrl_seq.sv
// tb_ir_ctrl_seq: scoreboard bench for ir_ctrl_seq
module tb_ir_ctrl_seq;
  logic clk = 0, rst, zero, mem_ack;
  logic [3:0] opcode;
  logic ir_re, pc_inc, pc_load, mem_req, mem_we, addr_sel, acc_we, acc_src, halted, fault;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
  logic [16:0] sb[$];
  int n_chk = 0, n_fail = 0;
  wire [16:0] outv = {state_dbg, ir_re, pc_inc, pc_load, mem_req, mem_we, addr_sel, alu_op, acc_we, acc_src, halted, fault};
  ir_ctrl_seq #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .ir_re(ir_re), .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_op(alu_op), .acc_we(acc_we), .acc_src(acc_src),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] exp_of(input logic [3:0] st, input logic [3:0] op, input logic z);
    logic [2:0] a;
    a = 3'd0;
    if (st == 4 || st == 6)
      case (op)
        4'h4: a = 3'd1;
        4'h5: a = 3'd2;
        4'h6: a = 3'd3;
        4'h7: a = 3'd4;
        4'h8: a = 3'd5;
        4'h9: a = 3'd6;
        4'hA: a = 3'd7;
        default: a = 3'd0;
      endcase
    return {st, st == 2, st == 2, st == 4 && (op == 4'hB || (op == 4'hC && z)), st == 1 || st == 5,
            st == 5 && op == 4'h2, st == 5, a, st == 6, st == 6 && op == 4'h1, st == 7, st == 8};
  endfunction
  always @(negedge clk)
    if (sb.size() > 0) begin
      logic [16:0] e;
      e = sb.pop_front();
      chk($sformatf("st%0d", e[16:13]), outv, e);
    end
  task automatic cyc(input logic [3:0] st, input logic [3:0] op, input logic a, input logic z, input logic [3:0] opc);
    opcode = opc;
    mem_ack = a;
    zero = z;
    sb.push_back(exp_of(st, op, z));
    @(posedge clk);
    #1;
  endtask
  task automatic fld(input logic [3:0] opc);
    cyc(1, opc, 1, 0, opc);
    cyc(2, opc, 1, 0, opc);
    cyc(3, opc, 0, 0, opc);
  endtask
  task automatic do_reset;
    rst = 1;
    @(negedge clk);
    chk("rst_out", outv, 0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 1, 0, 0);
  endtask
  initial begin
    rst = 1;
    opcode = 0;
    mem_ack = 0;
    zero = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", outv, 0);
    end
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 0, 0, 0);
    fld(4'h3);
    cyc(4, 4'h3, 0, 0, 4'hD);
    cyc(6, 4'h3, 0, 0, 4'hD);
    for (int i = 4; i <= 10; i++) begin
      fld(4'(i));
      cyc(4, 4'(i), 0, 0, 4'(i));
      cyc(6, 4'(i), 0, 0, 4'(i));
    end
    fld(4'h1);
    cyc(5, 4'h1, 0, 0, 4'h1);
    cyc(5, 4'h1, 0, 0, 4'h1);
    cyc(5, 4'h1, 1, 0, 4'h1);
    cyc(6, 4'h1, 0, 0, 4'h1);
    fld(4'h2);
    cyc(5, 4'h2, 1, 0, 4'h2);
    fld(4'hB);
    cyc(4, 4'hB, 0, 0, 4'hB);
    fld(4'hC);
    cyc(4, 4'hC, 0, 1, 4'hC);
    fld(4'hC);
    cyc(4, 4'hC, 0, 0, 4'hC);
    fld(4'h0);
    repeat (15) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(2, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    fld(4'h1);
    cyc(5, 4'h1, 0, 0, 4'h1);
    chk("mem_req_pre", mem_req, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("mem_req_async", mem_req, 0);
    chk("state_async", state_dbg, 0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 0, 0, 0);
    fld(4'h0);
    repeat (16) cyc(1, 0, 0, 0, 0);
    repeat (20) cyc(8, 0, 1, 0, 0);
    do_reset;
    fld(4'hD);
    repeat (20) cyc(8, 4'hD, 1, 1, 4'h0);
    do_reset;
    fld(4'hF);
    for (int i = 0; i < 10; i++) cyc(7, 4'hF, 1'(i), 0, 4'h0);
    do_reset;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
